// File: rtl/mem_interface_pkg.sv
// Shared definitions for the memory-side stage: access FSM encoding and RAM geometry.
package mem_interface_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 9;
    localparam int MEM_DEPTH  = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Access sequencer: state register, wait-state counter, registered RAM strobes
// and the one-cycle done/err completion pulses.
module mem_access_fsm
    import mem_interface_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic   clk,
    input  logic   clr,
    input  logic   read_req,
    input  logic   write_req,
    input  logic   in_range,
    output state_t state,
    output logic   ram_read,
    output logic   ram_write,
    output logic   done,
    output logic   err,
    output logic   capture
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       read_next;
    logic       write_next;
    logic       done_next;
    logic       err_next;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            ram_read  <= read_next;
            ram_write <= write_next;
            done      <= done_next;
            err       <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        read_next  = ram_read;
        write_next = ram_write;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                // Conflicting or out-of-range requests complete with an error and never strobe the RAM.
                if ((read_req && write_req) || ((read_req || write_req) && !in_range)) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else if (read_req) begin
                    state_next = ACCESS;
                    cnt_next   = WAIT_INIT;
                    read_next  = 1'b1;
                end else if (write_req) begin
                    state_next = ACCESS;
                    cnt_next   = WAIT_INIT;
                    write_next = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_next = DONE;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                read_next  = 1'b0;
                write_next = 1'b0;
            end
        endcase
    end

    // MDR samples RAM data on the edge that ends the final read strobe cycle.
    assign capture = ram_read && (state == ACCESS) && (cnt == 4'd0);

endmodule

// File: rtl/mem_interface.sv
// Memory-side stage: MAR/MDR registers in front of the 512x32 RAM, with the
// access sequencing delegated to mem_access_fsm.
module mem_interface
    import mem_interface_pkg::*;
#(
    parameter int DATA_W      = MEM_DATA_W,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mem_read_req,
    input  logic              mem_write_req,
    output logic [DATA_W-1:0] mdr_q,
    output logic              mem_done,
    output logic              mem_err,
    output logic              busy,
    output logic [31:0]       ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_data_out
);

    state_t            state;
    logic [31:0]       mar;
    logic [31:0]       mar_next;
    logic [DATA_W-1:0] mdr;
    logic              in_range;
    logic              capture;

    // A load in the same IDLE cycle as a request is visible to that request's range check.
    assign mar_next = (!busy && mar_in) ? 32'(bus_in) : mar;
    assign in_range = (mar_next >> ADDR_W) == 32'd0;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            mar <= mar_next;
            if (!busy && mdr_in) begin
                mdr <= bus_in;
            end else if (capture) begin
                mdr <= ram_data_out;
            end
        end
    end

    mem_access_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fsm (
        .clk       (clk),
        .clr       (clr),
        .read_req  (mem_read_req),
        .write_req (mem_write_req),
        .in_range  (in_range),
        .state     (state),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .done      (mem_done),
        .err       (mem_err),
        .capture   (capture)
    );

    assign mdr_q       = mdr;
    assign ram_address = mar;
    assign ram_data_in = mdr;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: a zero-wait-state instance and a three-wait-state
// instance, each in front of a 512x32 RAM model with combinational read.
module tb_mem_interface;

    localparam int W3 = 3;

    logic clk;
    logic clr;

    // Zero-wait instance
    logic [31:0] f_bus, f_mdr, f_addr, f_din, f_dout;
    logic        f_mar_in, f_mdr_in, f_rd, f_wr, f_done, f_err, f_busy, f_rr, f_rw;
    logic [31:0] f_ram [512];

    // Three-wait instance
    logic [31:0] s_bus, s_mdr, s_addr, s_din, s_dout;
    logic        s_mar_in, s_mdr_in, s_rd, s_wr, s_done, s_err, s_busy, s_rr, s_rw;
    logic [31:0] s_ram [512];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic        err_q [$];
    logic [31:0] model_mdr;
    logic [31:0] model_mar;
    int          rr_cnt, done_cnt;

    mem_interface #(.WAIT_CYCLES(0)) u_fast (
        .clk(clk), .clr(clr), .bus_in(f_bus), .mar_in(f_mar_in), .mdr_in(f_mdr_in),
        .mem_read_req(f_rd), .mem_write_req(f_wr), .mdr_q(f_mdr), .mem_done(f_done),
        .mem_err(f_err), .busy(f_busy), .ram_address(f_addr), .ram_data_in(f_din),
        .ram_read(f_rr), .ram_write(f_rw), .ram_data_out(f_dout)
    );

    mem_interface #(.WAIT_CYCLES(W3)) u_slow (
        .clk(clk), .clr(clr), .bus_in(s_bus), .mar_in(s_mar_in), .mdr_in(s_mdr_in),
        .mem_read_req(s_rd), .mem_write_req(s_wr), .mdr_q(s_mdr), .mem_done(s_done),
        .mem_err(s_err), .busy(s_busy), .ram_address(s_addr), .ram_data_in(s_din),
        .ram_read(s_rr), .ram_write(s_rw), .ram_data_out(s_dout)
    );

    // Clock and RAM models
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign f_dout = f_ram[f_addr[8:0]];
    assign s_dout = s_ram[s_addr[8:0]];

    always @(posedge clk) begin
        if (f_rw) f_ram[f_addr[8:0]] <= f_din;
        if (s_rw) s_ram[s_addr[8:0]] <= s_din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion on the slow instance pops one expectation.
    always @(negedge clk) begin
        if (s_done) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_done observed=1 expected=0");
            end
            if (exp_q.size() != 0) begin
                chk("sb_mdr", s_mdr, exp_q.pop_front());
                chk("sb_err", {31'd0, s_err}, {31'd0, err_q.pop_front()});
            end
        end
    end

    task automatic load_mar(input logic [31:0] v);
        s_bus = v; s_mar_in = 1'b1; tick(); s_mar_in = 1'b0;
        model_mar = v;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        s_bus = v; s_mdr_in = 1'b1; tick(); s_mdr_in = 1'b0;
        model_mdr = v;
    endtask

    // One request on the slow instance; request is sampled at the first edge.
    task automatic s_access(input logic rd, input logic wr, input logic [31:0] exp_data,
                            input logic exp_err, input logic busy_load);
        s_rd = rd; s_wr = wr;
        exp_q.push_back(exp_data);
        err_q.push_back(exp_err);
        tick();
        s_rd = 1'b0; s_wr = 1'b0; s_mar_in = 1'b0; s_mdr_in = 1'b0;
        if (!exp_err) begin
            if (busy_load) begin
                s_bus = 32'hFF; s_mdr_in = 1'b1;
            end
            for (int i = 0; i <= W3; i++) begin
                chk("strobe_rd", {31'd0, s_rr}, {31'd0, rd});
                chk("strobe_wr", {31'd0, s_rw}, {31'd0, wr});
                chk("strobe_addr", s_addr, model_mar);
                chk("early_done", {31'd0, s_done}, 32'd0);
                if (wr) chk("strobe_data", s_din, model_mdr);
                tick();
            end
        end else begin
            chk("err_no_rd", {31'd0, s_rr}, 32'd0);
            chk("err_no_wr", {31'd0, s_rw}, 32'd0);
        end
        chk("done", {31'd0, s_done}, 32'd1);
        chk("err", {31'd0, s_err}, {31'd0, exp_err});
        chk("done_no_strobe", {30'd0, s_rr, s_rw}, 32'd0);
        s_mdr_in = 1'b0;
        model_mdr = exp_data;
        tick();
        chk("back_idle", {30'd0, s_busy, s_done}, 32'd0);
    endtask

    initial begin
        clr = 1'b0;
        f_bus = '0; f_mar_in = 0; f_mdr_in = 0; f_rd = 0; f_wr = 0;
        s_bus = '0; s_mar_in = 0; s_mdr_in = 0; s_rd = 0; s_wr = 0;
        model_mdr = '0; model_mar = '0;
        for (int i = 0; i < 512; i++) begin
            f_ram[i] = $urandom_range(32'hFFFF, 0) | 32'h100;
            s_ram[i] = $urandom_range(32'hFFFF, 0) | 32'h100;
        end
        f_ram[149] = 32'h0000000D;
        tick(); tick();
        chk("rst_mdr", s_mdr, 32'd0);
        chk("rst_addr", s_addr, 32'd0);
        chk("rst_busy", {31'd0, s_busy}, 32'd0);
        chk("rst_strobes", {30'd0, s_rr, s_rw}, 32'd0);
        chk("rst_done_err", {30'd0, s_done, s_err}, 32'd0);
        #2 clr = 1'b1;
        tick();

        // Zero-wait read of RAM[149]
        f_bus = 32'd149; f_mar_in = 1'b1; tick(); f_mar_in = 1'b0;
        f_rd = 1'b1; tick(); f_rd = 1'b0;
        chk("f_rd_strobe", {31'd0, f_rr}, 32'd1);
        chk("f_addr", f_addr, 32'd149);
        chk("f_no_done", {31'd0, f_done}, 32'd0);
        tick();
        chk("f_rd_off", {31'd0, f_rr}, 32'd0);
        chk("f_done", {31'd0, f_done}, 32'd1);
        chk("f_err", {31'd0, f_err}, 32'd0);
        chk("f_mdr", f_mdr, 32'h0000000D);
        tick();
        chk("f_done_once", {30'd0, f_done, f_busy}, 32'd0);

        // Write 0x43 to 0x87 with three wait states, then read it back
        load_mar(32'h87);
        load_mdr(32'h43);
        s_access(1'b0, 1'b1, 32'h43, 1'b0, 1'b0);
        chk("ram_written", s_ram[9'h87], 32'h43);
        load_mdr(32'h0);
        s_access(1'b1, 1'b0, 32'h43, 1'b0, 1'b0);

        // Out-of-range read: error, MDR unchanged
        load_mar(32'h200);
        s_access(1'b1, 1'b0, model_mdr, 1'b1, 1'b0);

        // Both requests at once
        load_mar(32'h12);
        s_access(1'b1, 1'b1, model_mdr, 1'b1, 1'b0);

        // MDR load attempted while busy is ignored
        load_mar(32'h10);
        s_access(1'b1, 1'b0, s_ram[9'h10], 1'b0, 1'b1);

        // MAR load and request in the same IDLE cycle
        s_bus = 32'h21; s_mar_in = 1'b1; model_mar = 32'h21;
        s_access(1'b1, 1'b0, s_ram[9'h21], 1'b0, 1'b0);

        // Reset during the second ACCESS cycle
        load_mar(32'h30);
        s_rd = 1'b1; tick(); s_rd = 1'b0;
        tick();
        chk("pre_rst_strobe", {31'd0, s_rr}, 32'd1);
        #2 clr = 1'b0;
        #1;
        chk("mid_rst_strobe", {31'd0, s_rr}, 32'd0);
        chk("mid_rst_mar", s_addr, 32'd0);
        chk("mid_rst_mdr", s_mdr, 32'd0);
        chk("mid_rst_busy", {31'd0, s_busy}, 32'd0);
        #2 clr = 1'b1;
        model_mdr = '0; model_mar = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_quiet", {29'd0, s_done, s_busy, s_rr}, 32'd0);
        end
        load_mar(32'h30);
        s_access(1'b1, 1'b0, s_ram[9'h30], 1'b0, 1'b0);

        // Back-to-back: read 0x40, then write that data to 0x41 on the first IDLE cycle
        load_mar(32'h40);
        s_access(1'b1, 1'b0, s_ram[9'h40], 1'b0, 1'b0);
        s_bus = 32'h41; s_mar_in = 1'b1; model_mar = 32'h41;
        s_access(1'b0, 1'b1, model_mdr, 1'b0, 1'b0);
        chk("b2b_written", s_ram[9'h41], s_ram[9'h40]);

        // Request held high: one access per IDLE acceptance
        load_mar(32'h55);
        exp_q.push_back(s_ram[9'h55]); err_q.push_back(1'b0);
        exp_q.push_back(s_ram[9'h55]); err_q.push_back(1'b0);
        rr_cnt = 0; done_cnt = 0;
        s_rd = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_rr) rr_cnt++;
            if (s_done) done_cnt++;
        end
        s_rd = 1'b0;
        chk("held_strobe_cycles", rr_cnt, 32'd8);
        chk("held_done_count", done_cnt, 32'd2);
        tick(); tick();
        chk("held_idle", {31'd0, s_busy}, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
